// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution output path.
package conv_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } coll_state_t;

  // Address width of a D x D frame buffer.
  function automatic int frame_aw(input int d);
    return $clog2(d * d);
  endfunction

endpackage

// File: rtl/frame_ram_sp.sv
// Single-port frame buffer: synchronous write, registered read that holds while re is low.
module frame_ram_sp
  import conv_pkg::*;
#(
  parameter int DEPTH      = 9,
  parameter int AW         = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  re,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_r;

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Read data register, holds its value while no read is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_r <= {DATA_WIDTH{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/conv_out_collector.sv
// Packs D x D convolution pixels into a frame, then drains them in raster order.
// Optional CONV_COLLECT_RELU_EN: negative (MSB set) pixels are stored as zero.
module conv_out_collector
  import conv_pkg::*;
#(
  parameter int D          = 35,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  frame_done,
  output logic                  drop_err
);

  localparam int NPIX = D * D;
  localparam int CW   = $clog2(NPIX + 1);
  localparam int AW   = frame_aw(D);
  localparam logic [CW-1:0] LAST_WR  = CW'(NPIX - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(NPIX);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  coll_state_t           state_r;
  logic [CW-1:0]         wr_cnt_r;
  logic [CW-1:0]         rd_cnt_r;
  logic                  out_valid_r;
  logic                  frame_done_r;
  logic                  drop_err_r;

  logic                  we_s;
  logic                  re_s;
  logic                  last_xfer_s;
  logic [AW-1:0]         addr_s;
  logic [DATA_WIDTH-1:0] wdata_s;

  // RAM port steering and drain handshake decode.
  always_comb begin
    we_s        = (state_r == FILL) && valid_in;
    re_s        = (state_r == DRAIN) && (!out_valid_r || out_ready) && (rd_cnt_r < FULL_CNT);
    last_xfer_s = (state_r == DRAIN) && out_valid_r && out_ready && (rd_cnt_r == FULL_CNT);
    if (state_r == FILL) begin
      addr_s = wr_cnt_r[AW-1:0];
    end else begin
      addr_s = rd_cnt_r[AW-1:0];
    end
`ifdef CONV_COLLECT_RELU_EN
    if (pxl_in[DATA_WIDTH-1]) begin
      wdata_s = {DATA_WIDTH{1'b0}};
    end else begin
      wdata_s = pxl_in;
    end
`else
    wdata_s = pxl_in;
`endif
  end

  // Fill/drain sequencer with registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= FILL;
      wr_cnt_r     <= {CW{1'b0}};
      rd_cnt_r     <= {CW{1'b0}};
      out_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
      drop_err_r   <= 1'b0;
    end else begin
      case (state_r)
        FILL: begin
          frame_done_r <= 1'b0;
          if (valid_in) begin
            if (wr_cnt_r == LAST_WR) begin
              wr_cnt_r <= {CW{1'b0}};
              state_r  <= DRAIN;
            end else begin
              wr_cnt_r <= wr_cnt_r + CNT_ONE;
            end
          end
        end
        DRAIN: begin
          if (valid_in) begin
            drop_err_r <= 1'b1;
          end
          if (last_xfer_s) begin
            state_r      <= FILL;
            rd_cnt_r     <= {CW{1'b0}};
            out_valid_r  <= 1'b0;
            frame_done_r <= 1'b1;
          end else begin
            frame_done_r <= 1'b0;
            if (re_s) begin
              rd_cnt_r    <= rd_cnt_r + CNT_ONE;
              out_valid_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r      <= FILL;
          wr_cnt_r     <= {CW{1'b0}};
          rd_cnt_r     <= {CW{1'b0}};
          out_valid_r  <= 1'b0;
          frame_done_r <= 1'b0;
        end
      endcase
    end
  end

  frame_ram_sp #(
    .DEPTH      (NPIX),
    .AW         (AW),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we_s),
    .re    (re_s),
    .addr  (addr_s),
    .wdata (wdata_s),
    .rdata (pxl_out)
  );

  assign in_ready   = (state_r == FILL);
  assign out_valid  = out_valid_r;
  assign frame_done = frame_done_r;
  assign drop_err   = drop_err_r;

endmodule

// File: tb/tb_conv_out_collector.sv
// Self-checking bench for conv_out_collector (D=3) against a frame-level queue model.
module tb_conv_out_collector;

  localparam int D  = 3;
  localparam int N  = D * D;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          valid_in = 1'b0;
  logic [DW-1:0] pxl_in = 32'h0;
  logic          out_ready = 1'b1;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] pxl_out;
  logic          frame_done;
  logic          drop_err;

  always #5 clk = ~clk;

  conv_out_collector #(.D(D), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .pxl_in     (pxl_in),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pxl_out    (pxl_out),
    .frame_done (frame_done),
    .drop_err   (drop_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] relu_ref(input logic [31:0] x);
`ifdef CONV_COLLECT_RELU_EN
    if (x[31]) return 32'h0;
`endif
    return x;
  endfunction

  // ---------------- behavioural model + compare process ----------------
  bit          armed = 1'b0;
  bit          m_fill = 1'b1;
  logic [31:0] fill_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] cap_q[$];
  int          drain_cyc = 0;
  int          xfer_idx = 0;
  bit          all_rdy = 1'b0;
  bit          fd_exp = 1'b0;
  bit          fd_nxt = 1'b0;
  bit          drop_exp = 1'b0;
  bit          stall_prev = 1'b0;
  logic [31:0] hold_val = 32'h0;
  int          cyc = 0;
  int          fd_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (armed) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, m_fill});
      chk("frame_done", {31'b0, frame_done}, {31'b0, fd_exp});
      chk("drop_err", {31'b0, drop_err}, {31'b0, drop_exp});
      if (m_fill) chk("idle_out_valid", {31'b0, out_valid}, 32'h0);
      if (stall_prev) begin
        chk("hold_valid", {31'b0, out_valid}, 32'h1);
        chk("hold_data", pxl_out, hold_val);
      end
      if (frame_done) fd_cnt++;
    end
    if (reset) begin
      armed      = 1'b1;
      m_fill     = 1'b1;
      fill_q.delete();
      exp_q.delete();
      fd_exp     = 1'b0;
      drop_exp   = 1'b0;
      stall_prev = 1'b0;
      all_rdy    = 1'b0;
    end else if (armed) begin
      fd_nxt     = 1'b0;
      stall_prev = 1'b0;
      if (!m_fill && exp_q.size() > 0) begin
        if (cyc >= drain_cyc + 2 && !out_ready) all_rdy = 1'b0;
        if (out_valid && out_ready) begin
          chk("pixel", pxl_out, exp_q.pop_front());
          if (all_rdy) chk("latency", cyc, drain_cyc + 2 + xfer_idx);
          cap_q.push_back(pxl_out);
          xfer_idx++;
          if (xfer_idx == N) fd_nxt = 1'b1;
        end else if (out_valid) begin
          stall_prev = 1'b1;
          hold_val   = pxl_out;
        end
      end
      if (valid_in) begin
        if (m_fill) begin
          fill_q.push_back(relu_ref(pxl_in));
          if (fill_q.size() == N) begin
            exp_q     = fill_q;
            fill_q.delete();
            m_fill    = 1'b0;
            drain_cyc = cyc;
            xfer_idx  = 0;
            all_rdy   = 1'b1;
          end
        end else begin
          drop_exp = 1'b1;
        end
      end
      if (fd_nxt) m_fill = 1'b1;
      fd_exp = fd_nxt;
    end
  end

  // ---------------- stimulus ----------------
  int rdy_mode = 0;
  int rcnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // out_ready pattern generator: 0 = always, 1 = 1,0,0 repeating, 2 = random
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = (rcnt % 3 == 0); rcnt++; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  logic [31:0] fr [N];
  logic [31:0] ex [2*N];

  task automatic send_frame(input int gapmax, input bit first_nogap, input int npix);
    for (int i = 0; i < npix; i++) begin
      int g;
      g = (i == 0 && first_nogap) ? 0 : int'($urandom_range(0, gapmax));
      valid_in = 1'b0;
      repeat (g) tick();
      valid_in = 1'b1;
      pxl_in   = fr[i];
      tick();
      valid_in = 1'b0;
    end
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (fd_cnt < target && n < 500) begin
      tick();
      n++;
    end
    chk("frame_done_count", fd_cnt, target);
    tick();
  endtask

  task automatic chk_cap(input string name, input int len);
    chk({name, "_len"}, cap_q.size(), len);
    for (int i = 0; i < len && i < cap_q.size(); i++) chk(name, cap_q[i], ex[i]);
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic seq_frame(input logic [31:0] base);
    for (int i = 0; i < N; i++) begin
      fr[i] = base + 32'(i);
      ex[i] = base + 32'(i);
    end
  endtask

  initial begin
    int base_fd;
    int n;
    int dead;
    #1;
    do_reset();
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_pxl_out", pxl_out, 32'h0);
    chk("rst_frame_done", {31'b0, frame_done}, 32'h0);
    chk("rst_drop_err", {31'b0, drop_err}, 32'h0);

    // Basic fill/drain, out_ready held high
    rdy_mode = 0; cap_q.delete(); base_fd = fd_cnt;
    seq_frame(32'd1);
    send_frame(3, 1'b0, N);
    wait_done(base_fd + 1);
    chk_cap("basic", N);

    // Backpressure 1,0,0 pattern
    rdy_mode = 1; rcnt = 0; cap_q.delete(); base_fd = fd_cnt;
    seq_frame(32'd1);
    send_frame(2, 1'b0, N);
    wait_done(base_fd + 1);
    chk_cap("backpressure", N);

    // Drop during DRAIN, then a following frame
    rdy_mode = 2; cap_q.delete(); base_fd = fd_cnt;
    seq_frame(32'd20);
    send_frame(2, 1'b0, N);
    valid_in = 1'b1; pxl_in = 32'h0000DEAD;
    tick();
    valid_in = 1'b0;
    wait_done(base_fd + 1);
    seq_frame(32'd30);
    send_frame(2, 1'b0, N);
    wait_done(base_fd + 2);
    dead = 0;
    foreach (cap_q[i]) if (cap_q[i] == 32'h0000DEAD) dead++;
    chk("drop_not_output", dead, 0);
    chk("drop_cap_len", cap_q.size(), 2 * N);
    chk("drop_sticky", {31'b0, drop_err}, 32'h1);
    do_reset();
    chk("drop_cleared", {31'b0, drop_err}, 32'h0);

    // Reset after 5 pixels of FILL
    rdy_mode = 0; cap_q.delete();
    seq_frame(32'd101);
    send_frame(1, 1'b0, 5);
    do_reset();
    base_fd = fd_cnt;
    seq_frame(32'd10);
    send_frame(2, 1'b0, N);
    wait_done(base_fd + 1);
    chk_cap("reset_fill", N);

    // Reset during DRAIN
    rdy_mode = 1; rcnt = 0;
    seq_frame(32'd60);
    send_frame(1, 1'b0, N);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("drain_started", {31'b0, out_valid}, 32'h1);
    reset = 1'b1;
    tick();
    chk("rst_drain_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_drain_in_ready", {31'b0, in_ready}, 32'h1);
    reset = 1'b0;
    tick();

    // ReLU behaviour
    rdy_mode = 0; cap_q.delete(); base_fd = fd_cnt;
    fr[0] = 32'hFFFFFFFF; fr[1] = 32'h00000005; fr[2] = 32'h80000000;
    fr[3] = 32'h7FFFFFFF; fr[4] = 32'h00000000; fr[5] = 32'h00000001;
    fr[6] = 32'h80000001; fr[7] = 32'h12345678; fr[8] = 32'hC0000000;
`ifdef CONV_COLLECT_RELU_EN
    ex[0] = 32'h0; ex[1] = 32'h5; ex[2] = 32'h0; ex[3] = 32'h7FFFFFFF; ex[4] = 32'h0;
    ex[5] = 32'h1; ex[6] = 32'h0; ex[7] = 32'h12345678; ex[8] = 32'h0;
`else
    for (int i = 0; i < N; i++) ex[i] = fr[i];
`endif
    send_frame(1, 1'b0, N);
    wait_done(base_fd + 1);
    chk_cap("relu", N);

    // Back-to-back frames, second begins on the FILL re-entry cycle
    rdy_mode = 0; cap_q.delete(); base_fd = fd_cnt;
    seq_frame(32'd40);
    send_frame(2, 1'b0, N);
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    chk("reentry_in_ready", {31'b0, in_ready}, 32'h1);
    seq_frame(32'd50);
    send_frame(2, 1'b1, N);
    wait_done(base_fd + 2);
    for (int i = 0; i < N; i++) begin
      ex[i]     = 32'd40 + 32'(i);
      ex[N + i] = 32'd50 + 32'(i);
    end
    chk_cap("back2back", 2 * N);
    chk("b2b_drop_err", {31'b0, drop_err}, 32'h0);

    // Random frames with random backpressure
    rdy_mode = 2;
    for (int f = 0; f < 6; f++) begin
      base_fd = fd_cnt;
      for (int i = 0; i < N; i++) fr[i] = $urandom;
      send_frame(3, 1'b0, N);
      wait_done(base_fd + 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
